// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode-stage register storage: default sizes,
// the register address layout (vector select + index) and the mapping from
// a register address to its bit in the busy scoreboard.
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam int DEF_LANES    = 4;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_IDX_W    = $clog2(DEF_NUM_REGS);

    // Register address at default sizing: MSB selects the vector file.
    typedef struct packed {
        logic                 vec;
        logic [DEF_IDX_W-1:0] idx;
    } reg_addr_t;

    // Scoreboard layout: scalars occupy [NUM_REGS-1:0], vectors sit above.
    function automatic int unsigned busy_bit(input logic        is_vec,
                                             input int unsigned idx,
                                             input int unsigned num_regs);
        return is_vec ? (num_regs + idx) : idx;
    endfunction

endpackage

// File: rtl/regfile_masked_bank.sv
// ----------------------------------------------------------------------------
// regfile_masked_bank
// DEPTH x (32*LANES) register bank with one lane-masked write port and two
// combinational read ports. A read of the address being written in the same
// cycle returns the written lanes from wdata_i and the rest from storage.
//
// Ports:
//   clock, async_reset         clock, asynchronous active-low reset
//   we_i, waddr_i              write enable and address
//   wdata_i, wmask_i           write data and per-lane enable
//   raddr1_i, raddr2_i         read addresses
//   rdata1_o, rdata2_o         bypassed read data
// ----------------------------------------------------------------------------
module regfile_masked_bank #(
    parameter  int DEPTH = 32,
    parameter  int LANES = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int W     = 32 * LANES
) (
    input  logic             clock,
    input  logic             async_reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [LANES-1:0] wmask_i,
    input  logic [AW-1:0]    raddr1_i,
    input  logic [AW-1:0]    raddr2_i,
    output logic [W-1:0]     rdata1_o,
    output logic [W-1:0]     rdata2_o
);

    logic [W-1:0] mem_q [DEPTH];

    // NOTE: the storage is reset here because the architecture requires
    // every register to read zero after reset; this costs a reset net per
    // flop, so banks without that requirement should leave memories unreset.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_i[l]) begin
                    mem_q[waddr_i][l*32 +: 32] <= wdata_i[l*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rdata1_o[l*32 +: 32] = (we_i && waddr_i == raddr1_i && wmask_i[l])
                                   ? wdata_i[l*32 +: 32] : mem_q[raddr1_i][l*32 +: 32];
            rdata2_o[l*32 +: 32] = (we_i && waddr_i == raddr2_i && wmask_i[l])
                                   ? wdata_i[l*32 +: 32] : mem_q[raddr2_i][l*32 +: 32];
        end
    end

endmodule

// File: rtl/decode_scoreboard_regfile.sv
// ----------------------------------------------------------------------------
// decode_scoreboard_regfile
// Unified scalar/vector register file for the decode stage with a per-register
// busy scoreboard. Instructions issue only when none of their used sources or
// their destination is busy (a writeback in the same cycle counts as clearing
// the hazard). Writebacks are lane-masked for vectors and bypassed to reads.
//
// Ports:
//   clock, async_reset                 clock, asynchronous active-low reset
//   issue_valid / issue_ready          issue handshake
//   issue_r1, issue_r2, issue_rd       operand / destination (MSB = vector)
//   issue_rd_write, issue_r1_used,
//   issue_r2_used                      hazard qualifiers
//   r1_data, r2_data                   operand data (scalar zero-extended)
//   wb_valid, wb_addr, wb_data,
//   wb_lane_mask                       writeback port
//   flush                              clear the scoreboard
//   pending_count, busy_vec            scoreboard observability
// ----------------------------------------------------------------------------
module decode_scoreboard_regfile
    import decode_pkg::*;
#(
    parameter  int LANES    = DEF_LANES,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int CNT_W    = $clog2(2 * NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  async_reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [IDX_W:0]        issue_r1,
    input  logic [IDX_W:0]        issue_r2,
    input  logic [IDX_W:0]        issue_rd,
    input  logic                  issue_rd_write,
    input  logic                  issue_r1_used,
    input  logic                  issue_r2_used,
    output logic [32*LANES-1:0]   r1_data,
    output logic [32*LANES-1:0]   r2_data,
    input  logic                  wb_valid,
    input  logic [IDX_W:0]        wb_addr,
    input  logic [32*LANES-1:0]   wb_data,
    input  logic [LANES-1:0]      wb_lane_mask,
    input  logic                  flush,
    output logic [CNT_W:0]        pending_count,
    output logic [2*NUM_REGS-1:0] busy_vec
);

    localparam int AW = IDX_W + 1;
    localparam int VW = 32 * LANES;
    localparam int CW = CNT_W + 1;

    // ---------------------------------------------------------------- storage
    logic          sc_we, vec_we;
    logic [31:0]   sc_rd1, sc_rd2;
    logic [VW-1:0] vec_rd1, vec_rd2;

    // Scalar register 0 is hardwired to zero: never written, so never bypassed.
    assign sc_we  = wb_valid && !wb_addr[IDX_W] && (wb_addr[IDX_W-1:0] != '0);
    assign vec_we = wb_valid &&  wb_addr[IDX_W];

    regfile_masked_bank #(.DEPTH(NUM_REGS), .LANES(1)) u_scalar_bank (
        .clock      (clock),
        .async_reset(async_reset),
        .we_i       (sc_we),
        .waddr_i    (wb_addr[IDX_W-1:0]),
        .wdata_i    (wb_data[31:0]),
        .wmask_i    (1'b1),
        .raddr1_i   (issue_r1[IDX_W-1:0]),
        .raddr2_i   (issue_r2[IDX_W-1:0]),
        .rdata1_o   (sc_rd1),
        .rdata2_o   (sc_rd2)
    );

    regfile_masked_bank #(.DEPTH(NUM_REGS), .LANES(LANES)) u_vector_bank (
        .clock      (clock),
        .async_reset(async_reset),
        .we_i       (vec_we),
        .waddr_i    (wb_addr[IDX_W-1:0]),
        .wdata_i    (wb_data),
        .wmask_i    (wb_lane_mask),
        .raddr1_i   (issue_r1[IDX_W-1:0]),
        .raddr2_i   (issue_r2[IDX_W-1:0]),
        .rdata1_o   (vec_rd1),
        .rdata2_o   (vec_rd2)
    );

    assign r1_data = issue_r1[IDX_W] ? vec_rd1 : VW'(sc_rd1);
    assign r2_data = issue_r2[IDX_W] ? vec_rd2 : VW'(sc_rd2);

    // ------------------------------------------------------------- scoreboard
    logic [2*NUM_REGS-1:0] busy_q, busy_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         r1_pos, r2_pos, rd_pos, wb_pos;
    logic                  r1_blk, r2_blk, rd_blk;
    logic                  fire, set_en, inc, dec;

    assign r1_pos = AW'(busy_bit(issue_r1[IDX_W], 32'(issue_r1[IDX_W-1:0]), NUM_REGS));
    assign r2_pos = AW'(busy_bit(issue_r2[IDX_W], 32'(issue_r2[IDX_W-1:0]), NUM_REGS));
    assign rd_pos = AW'(busy_bit(issue_rd[IDX_W], 32'(issue_rd[IDX_W-1:0]), NUM_REGS));
    assign wb_pos = AW'(busy_bit(wb_addr[IDX_W],  32'(wb_addr[IDX_W-1:0]),  NUM_REGS));

    // A writeback landing this cycle resolves the hazard through the bypass.
    assign r1_blk = issue_r1_used  && busy_q[r1_pos] && !(wb_valid && wb_addr == issue_r1);
    assign r2_blk = issue_r2_used  && busy_q[r2_pos] && !(wb_valid && wb_addr == issue_r2);
    assign rd_blk = issue_rd_write && busy_q[rd_pos] && !(wb_valid && wb_addr == issue_rd);

    assign issue_ready = !flush && !r1_blk && !r2_blk && !rd_blk;
    assign fire        = issue_valid && issue_ready;
    assign set_en      = fire && issue_rd_write && (issue_rd != '0);

    // Counter tracks the popcount exactly: a set on an already-busy register
    // adds nothing, and a clear that is overridden by a set subtracts nothing.
    assign inc = set_en && !busy_q[rd_pos];
    assign dec = wb_valid && busy_q[wb_pos] && !(set_en && rd_pos == wb_pos);

    // NOTE: blocking assignments are correct inside always_comb, and every
    // output gets a default first so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q + CW'(inc) - CW'(dec);
        if (wb_valid) busy_d[wb_pos] = 1'b0;
        if (set_en)   busy_d[rd_pos] = 1'b1;  // set wins over a same-cycle clear
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_count = cnt_q;
    assign busy_vec      = busy_q;

endmodule

// File: tb/tb_decode_scoreboard_regfile.sv
// ----------------------------------------------------------------------------
// tb_decode_scoreboard_regfile
// Directed self-checking bench for decode_scoreboard_regfile at default size.
// Inputs change 1 ns after the rising edge; outputs are compared 2 ns later.
// ----------------------------------------------------------------------------
module tb_decode_scoreboard_regfile;
    import decode_pkg::*;

    localparam int LANES    = DEF_LANES;
    localparam int NUM_REGS = DEF_NUM_REGS;
    localparam int IDX_W    = DEF_IDX_W;
    localparam int CNT_W    = $clog2(2 * NUM_REGS);
    localparam int VW       = 32 * LANES;

    logic                  clock = 1'b0;
    logic                  async_reset;
    logic                  issue_valid, issue_ready;
    logic [IDX_W:0]        issue_r1, issue_r2, issue_rd;
    logic                  issue_rd_write, issue_r1_used, issue_r2_used;
    logic [VW-1:0]         r1_data, r2_data;
    logic                  wb_valid;
    logic [IDX_W:0]        wb_addr;
    logic [VW-1:0]         wb_data;
    logic [LANES-1:0]      wb_lane_mask;
    logic                  flush;
    logic [CNT_W:0]        pending_count;
    logic [2*NUM_REGS-1:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    decode_scoreboard_regfile dut (
        .clock         (clock),
        .async_reset   (async_reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_r1      (issue_r1),
        .issue_r2      (issue_r2),
        .issue_rd      (issue_rd),
        .issue_rd_write(issue_rd_write),
        .issue_r1_used (issue_r1_used),
        .issue_r2_used (issue_r2_used),
        .r1_data       (r1_data),
        .r2_data       (r2_data),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_lane_mask  (wb_lane_mask),
        .flush         (flush),
        .pending_count (pending_count),
        .busy_vec      (busy_vec)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [IDX_W:0] sa(input int i);
        reg_addr_t a;
        a.vec = 1'b0;
        a.idx = i[IDX_W-1:0];
        return a;
    endfunction

    function automatic logic [IDX_W:0] va(input int i);
        reg_addr_t a;
        a.vec = 1'b1;
        a.idx = i[IDX_W-1:0];
        return a;
    endfunction

    function automatic logic [2*NUM_REGS-1:0] bit_of(input int pos);
        logic [2*NUM_REGS-1:0] v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    task automatic idle();
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_rd_write = 1'b0;
        issue_r1_used  = 1'b0;
        issue_r2_used  = 1'b0;
        wb_valid       = 1'b0;
        wb_addr        = '0;
        wb_data        = '0;
        wb_lane_mask   = '0;
        flush          = 1'b0;
    endtask

    // Advance one clock; inputs may be changed afterwards.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue_write(input logic [IDX_W:0] rd);
        idle();
        issue_valid    = 1'b1;
        issue_rd       = rd;
        issue_rd_write = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        issue_r1    = sa(5);
        issue_r2    = va(3);
        async_reset = 1'b0;
        #12;
        settle();
        check("rst_r1_scalar5", r1_data, '0);
        check("rst_r2_vector3", r2_data, '0);
        check("rst_pending", 128'(pending_count), 128'd0);
        check("rst_busy", 128'(busy_vec), 128'd0);
        check("rst_ready", 128'(issue_ready), 128'd1);
        @(negedge clock);
        async_reset = 1'b1;
        tick();

        // ---- RAW hazard on scalar 7, resolved by a bypassed writeback
        issue_write(sa(7));
        settle();
        check("raw_busy7", 128'(busy_vec), 128'(bit_of(7)));
        check("raw_pending1", 128'(pending_count), 128'd1);
        idle();
        issue_valid   = 1'b1;
        issue_r1      = sa(7);
        issue_r1_used = 1'b1;
        settle();
        check("raw_blocked", 128'(issue_ready), 128'd0);
        tick();
        settle();
        check("raw_still_blocked", 128'(issue_ready), 128'd0);
        wb_valid = 1'b1;
        wb_addr  = sa(7);
        wb_data  = 128'hDEADBEEF;
        settle();
        check("raw_wb_ready", 128'(issue_ready), 128'd1);
        check("raw_bypass", r1_data, 128'hDEADBEEF);
        tick();
        idle();
        issue_r2 = sa(7);
        settle();
        check("raw_cleared", 128'(pending_count), 128'd0);
        check("raw_storage_zext", r2_data, 128'hDEADBEEF);

        // ---- r2_used qualifier on a busy scalar 12
        issue_write(sa(12));
        idle();
        issue_valid = 1'b1;
        issue_r2    = sa(12);
        settle();
        check("r2_unused_ready", 128'(issue_ready), 128'd1);
        issue_r2_used = 1'b1;
        settle();
        check("r2_used_blocked", 128'(issue_ready), 128'd0);
        idle();
        wb_valid = 1'b1;
        wb_addr  = sa(12);
        tick();

        // ---- lane-masked vector writeback on vector 2
        idle();
        wb_valid     = 1'b1;
        wb_addr      = va(2);
        wb_data      = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        wb_lane_mask = 4'b1111;
        tick();
        wb_data      = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        wb_lane_mask = 4'b0101;
        issue_r1     = va(2);
        settle();
        check("mask_bypass", r1_data,
              {32'h44444444, 32'hBBBBBBBB, 32'h22222222, 32'hDDDDDDDD});
        tick();
        idle();
        settle();
        check("mask_storage", r1_data,
              {32'h44444444, 32'hBBBBBBBB, 32'h22222222, 32'hDDDDDDDD});
        check("mask_no_busy", 128'(pending_count), 128'd0);

        // ---- same-cycle clear and set on vector 9 (set wins)
        issue_write(va(9));
        settle();
        check("v9_busy", 128'(busy_vec), 128'(bit_of(NUM_REGS + 9)));
        idle();
        issue_valid    = 1'b1;
        issue_rd       = va(9);
        issue_rd_write = 1'b1;
        wb_valid       = 1'b1;
        wb_addr        = va(9);
        wb_lane_mask   = 4'b1111;
        settle();
        check("v9_waw_cleared_ready", 128'(issue_ready), 128'd1);
        tick();
        idle();
        settle();
        check("v9_set_wins", 128'(busy_vec), 128'(bit_of(NUM_REGS + 9)));
        check("v9_count_same", 128'(pending_count), 128'd1);
        wb_valid = 1'b1;
        wb_addr  = va(9);
        tick();
        idle();
        settle();
        check("v9_cleared", 128'(pending_count), 128'd0);

        // ---- scalar 0 is never written and never busy
        idle();
        issue_valid    = 1'b1;
        issue_rd       = sa(0);
        issue_rd_write = 1'b1;
        wb_valid       = 1'b1;
        wb_addr        = sa(0);
        wb_data        = 128'h1234;
        issue_r1       = sa(0);
        settle();
        check("s0_bypass_zero", r1_data, '0);
        tick();
        idle();
        settle();
        check("s0_not_busy", 128'(busy_vec), 128'd0);
        check("s0_count", 128'(pending_count), 128'd0);
        check("s0_reads_zero", r1_data, '0);

        // ---- flush with three busy registers
        issue_write(sa(3));
        issue_write(sa(4));
        issue_write(va(5));
        idle();
        settle();
        check("flush_pre_count", 128'(pending_count), 128'd3);
        flush          = 1'b1;
        issue_valid    = 1'b1;
        issue_rd       = sa(6);
        issue_rd_write = 1'b1;
        wb_valid       = 1'b1;
        wb_addr        = sa(10);
        wb_data        = 128'h55;
        settle();
        check("flush_ready_low", 128'(issue_ready), 128'd0);
        tick();
        idle();
        issue_r1 = sa(10);
        settle();
        check("flush_busy", 128'(busy_vec), 128'd0);
        check("flush_count", 128'(pending_count), 128'd0);
        check("flush_wb_written", r1_data, 128'h55);

        // ---- reset mid-operation
        issue_write(sa(8));
        idle();
        #1;
        async_reset = 1'b0;
        #1;
        check("midrst_count", 128'(pending_count), 128'd0);
        check("midrst_storage", r1_data, '0);
        @(negedge clock);
        async_reset = 1'b1;
        tick();
        settle();
        check("postrst_busy", 128'(busy_vec), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard_regfile.md
# decode_scoreboard_regfile

Parametrised successor of the decode-stage register storage: a unified scalar/vector register file with a per-register busy scoreboard, an issue handshake that stalls on RAW/WAW hazards, lane-masked vector writeback and same-cycle writeback bypass. It sits in the decode stage between the instruction decoder and the ID/EX pipeline register and is written from the writeback stage.

## Interface
Parameters:
- LANES, 4, 32-bit lanes per vector register (vector width = 32*LANES)
- NUM_REGS, 32, registers per file (power of two)
- IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden)
- CNT_W, $clog2(2*NUM_REGS), pending-count width (derived)

Ports:
- clock  in  1  rising-edge clock
- async_reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  decoder presents an instruction
- issue_ready  out  1  no hazard; instruction may issue this cycle
- issue_r1, issue_r2  in  IDX_W+1  source operand addresses, MSB = vector file select
- issue_rd  in  IDX_W+1  destination address, MSB = vector file select
- issue_rd_write  in  1  instruction writes issue_rd
- issue_r1_used, issue_r2_used  in  1  operand is actually read (hazard-check qualifier)
- r1_data, r2_data  out  32*LANES  operand data; scalar reads zero-extended into the low lane
- wb_valid  in  1  writeback strobe
- wb_addr  in  IDX_W+1  writeback address, MSB = vector select
- wb_data  in  32*LANES  writeback data; scalar uses [31:0]
- wb_lane_mask  in  LANES  per-lane write enable for vector writebacks; ignored for scalar
- flush  in  1  clear all busy bits (branch mispredict)
- pending_count  out  CNT_W+1  number of busy registers
- busy_vec  out  2*NUM_REGS  scoreboard, debug/observability; bit i = scalar i, bit NUM_REGS+i = vector i

## Operation
- Storage: scalar file NUM_REGS×32, vector file NUM_REGS×(32*LANES). Scalar register 0 reads 0, is never written, never busy.
- Reads are combinational. Bypass: if wb_valid and wb_addr equals the read address in the same cycle, the written value is returned (vector: written lanes from wb_data, unwritten lanes from storage).
- Hazard: operand k is blocked when issue_rk_used and busy[rk] and not (wb_valid and wb_addr==rk). Destination is blocked (WAW) when issue_rd_write and busy[rd] and not the same clearing writeback.
- issue_ready = not flush and no blocked operand or destination. Fire = issue_valid & issue_ready.
- On fire with issue_rd_write and rd ≠ scalar 0: set busy[rd].
- On wb_valid: write storage (vector: masked lanes only) and clear busy[wb_addr].
- Same register set by fire and cleared by wb in one cycle: set wins.
- flush: all busy bits clear at the next edge; wb write still occurs; no fire that cycle.
- pending_count = population count of busy bits, maintained as an up/down counter (+1 on set, −1 on clear of a busy bit, net 0 when both hit the same register, 0 on flush).
- Writeback to a non-busy register is legal: data written, count unchanged.

## Timing
- Reset (async_reset low): all storage 0, all busy 0, pending_count 0; issue_ready reflects only combinational inputs (1 with no flush).
- Reset mid-operation discards pending writes immediately; no outputs glitch back after release.
- Read latency 0 cycles; writeback visible to reads in the same cycle (bypass) and from storage on the next.
- Scoreboard update latency 1 cycle: an instruction issued in cycle n makes its rd busy from cycle n+1.
- issue_ready depends combinationally on issue_*, wb_* and flush; no combinational path from issue_valid to issue_ready.

## Structure
- Shared package decode_pkg: reg address typedef (vector select + index), function for busy-vector bit position, LANES/NUM_REGS defaults.
- One sub-module: regfile_masked_bank (parametrised depth × LANES×32 storage with lane mask, async active-low reset), instantiated twice (scalar with LANES=1).

## Test plan
- Reset then read scalar 5 and vector 3 -> r1_data = 0; pending_count = 0; issue_ready = 1.
- Issue rd=scalar 7, next cycle issue r1=scalar 7 -> second blocked (issue_ready=0) until wb_valid with wb_addr=7, wb_data=0xDEADBEEF, in which cycle issue_ready=1 and r1_data=0xDEADBEEF.
- Vector 2 holds 0x4444_3333_2222_1111; wb mask 4'b0101 data 0xAAAA_BBBB_CCCC_DDDD -> reads 0x4444_BBBB_2222_DDDD.
- Same cycle: wb clears vector 9 and new instruction issues rd=vector 9 -> busy[vector 9]=1 next cycle, pending_count unchanged.
- Issue rd=scalar 0 with rd_write, write 0x1234 to scalar 0 -> never busy, reads 0, count 0.
- Three registers busy, flush asserted -> issue_ready=0 that cycle, busy_vec=0 and pending_count=0 next cycle.
